// File: rtl/xbar_slave_arbiter_if.sv
// Master-side and slave-side channels of one cross-bar slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric's view.
interface xbar_slave_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0]    m_req;
  logic [NUM_MASTERS*32-1:0] m_addr;
  logic [NUM_MASTERS-1:0]    m_cmd;
  logic [NUM_MASTERS*32-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]    m_ack;
  logic [NUM_MASTERS*32-1:0] m_rdata;
  logic [NUM_MASTERS-1:0]    m_resp;
  logic                      s_req;
  logic [31:0]               s_addr;
  logic                      s_cmd;
  logic [31:0]               s_wdata;
  logic                      s_ack;
  logic [31:0]               s_rdata;
  logic                      s_resp;

  modport slave (
    input  m_req, m_addr, m_cmd, m_wdata, s_ack, s_rdata, s_resp,
    output m_ack, m_rdata, m_resp, s_req, s_addr, s_cmd, s_wdata
  );

  modport master (
    output m_req, m_addr, m_cmd, m_wdata, s_ack, s_rdata, s_resp,
    input  m_ack, m_rdata, m_resp, s_req, s_addr, s_cmd, s_wdata
  );
endinterface

// File: rtl/xbar_slave_arbiter.sv
// Round-robin arbiter sharing one cross-bar slave port, with in-order read-response routing.
// Optional per-master grant counters and peak-outstanding tracking under XBAR_ARB_STATS_EN.
module xbar_slave_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned RD_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  xbar_slave_arbiter_if.slave        bus,
  output logic                       busy,
  output logic                       resp_err
`ifdef XBAR_ARB_STATS_EN
  ,
  output logic [NUM_MASTERS*16-1:0]  grant_cnt,
  output logic [$clog2(RD_DEPTH):0]  max_outstanding
`endif
);
  localparam int unsigned ID_W  = $clog2(NUM_MASTERS);
  localparam int unsigned PTR_W = $clog2(RD_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_gnt;
  logic [ID_W-1:0]  r_last;
  logic [ID_W-1:0]  r_fifo [RD_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_resp_err;

  logic                   w_grant;
  logic                   w_full;
  logic                   w_empty;
  logic [NUM_MASTERS-1:0] w_elig;
  logic                   w_pick_vld;
  logic [ID_W-1:0]        w_pick;
  logic                   w_sel_req;
  logic                   w_sel_cmd;
  logic [31:0]            w_sel_addr;
  logic [31:0]            w_sel_wdata;
  logic                   w_push;
  logic                   w_pop;
  logic [ID_W-1:0]        w_head;
  logic [CNT_W-1:0]       w_cnt_nxt;

  assign w_grant = (r_state == S_GRANT);
  assign w_full  = (r_cnt == CNT_W'(RD_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_elig  = bus.m_req & (bus.m_cmd | {NUM_MASTERS{~w_full}});
  assign w_push  = w_grant & bus.s_ack & ~w_sel_cmd;
  assign w_pop   = bus.s_resp & ~w_empty;
  assign w_head  = r_fifo[r_rptr];
  assign busy    = w_grant | ~w_empty;
  assign resp_err = r_resp_err;

  // Rotating search starting just after the last completed grant.
  always_comb begin
    logic [ID_W-1:0] w_idx;
    w_pick_vld = 1'b0;
    w_pick     = '0;
    w_idx      = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      w_idx = ID_W'((32'(r_last) + k) % NUM_MASTERS);
      if (!w_pick_vld && w_elig[w_idx]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_req   = 1'b0;
    w_sel_cmd   = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (r_gnt == ID_W'(i)) begin
        w_sel_req   = bus.m_req[i];
        w_sel_cmd   = bus.m_cmd[i];
        w_sel_addr  = bus.m_addr[32*i +: 32];
        w_sel_wdata = bus.m_wdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + CNT_W'(1);
    else if (!w_push && w_pop) w_cnt_nxt = r_cnt - CNT_W'(1);
  end

  // Slave-side request is zeroed outside GRANT so everything idles low in reset.
  always_comb begin
    bus.s_req   = w_grant;
    bus.s_cmd   = w_grant & w_sel_cmd;
    bus.s_addr  = w_grant ? w_sel_addr  : '0;
    bus.s_wdata = w_grant ? w_sel_wdata : '0;
    bus.m_ack   = '0;
    bus.m_resp  = '0;
    bus.m_rdata = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      bus.m_ack[i]  = w_grant & bus.s_ack & (r_gnt == ID_W'(i));
      bus.m_resp[i] = w_pop & (w_head == ID_W'(i));
      if (w_pop && (w_head == ID_W'(i))) bus.m_rdata[32*i +: 32] = bus.s_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_last     <= ID_W'(NUM_MASTERS - 1);
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_resp_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_gnt   <= w_pick;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          // A master withdrawing before the slave accepts is dropped without updating fairness.
          if (bus.s_ack) begin
            r_last  <= r_gnt;
            r_state <= S_IDLE;
          end else if (!w_sel_req) begin
            r_state <= S_IDLE;
          end
        end
      endcase
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_cnt <= w_cnt_nxt;
      if (bus.s_resp && w_empty) r_resp_err <= 1'b1;
    end
  end

  // Read-ID storage carries no reset; occupancy is governed by r_cnt.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= r_gnt;
  end

`ifdef XBAR_ARB_STATS_EN
  logic [15:0]      r_gcnt [NUM_MASTERS];
  logic [CNT_W-1:0] r_max_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_MASTERS); i++) r_gcnt[i] <= '0;
      r_max_out <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
        if (w_grant && bus.s_ack && (r_gnt == ID_W'(i)) && (r_gcnt[i] != 16'hFFFF))
          r_gcnt[i] <= r_gcnt[i] + 16'd1;
      end
      if (w_cnt_nxt > r_max_out) r_max_out <= w_cnt_nxt;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) grant_cnt[16*i +: 16] = r_gcnt[i];
  end

  assign max_outstanding = r_max_out;
`endif
endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Self-checking bench for xbar_slave_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based transaction model of the arbitration and read-return rules.
module tb_xbar_slave_arbiter;
  localparam int N = 2;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy, resp_err;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: grant-in-progress flag, chosen master, last completed grant, outstanding read IDs.
  bit mdl_active;
  int mdl_gnt;
  int mdl_last;
  int mdl_q[$];
  bit mdl_err;

  always #5 clk = ~clk;

  xbar_slave_arbiter_if #(.NUM_MASTERS(N)) bus ();

`ifdef XBAR_ARB_STATS_EN
  logic [N*16-1:0]      grant_cnt;
  logic [$clog2(D):0]   max_out;
  xbar_slave_arbiter #(.NUM_MASTERS(N), .RD_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .resp_err(resp_err),
    .grant_cnt(grant_cnt), .max_outstanding(max_out));
`else
  xbar_slave_arbiter #(.NUM_MASTERS(N), .RD_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .resp_err(resp_err));
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic mdl_reset();
    mdl_active = 0; mdl_gnt = 0; mdl_last = N - 1; mdl_q.delete(); mdl_err = 0;
  endtask

  function automatic int mdl_pick();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (mdl_last + k) % N;
      if (bus.m_req[i] && (bus.m_cmd[i] || mdl_q.size() < D)) return i;
    end
    return -1;
  endfunction

  task automatic mdl_step();
    int w; bit push; int pid;
    w = mdl_pick(); push = 0; pid = mdl_gnt;
    if (mdl_active) begin
      if (bus.s_ack) begin
        mdl_last = mdl_gnt; push = !bus.m_cmd[mdl_gnt]; mdl_active = 0;
      end else if (!bus.m_req[mdl_gnt]) mdl_active = 0;
    end else if (w >= 0) begin
      mdl_active = 1; mdl_gnt = w;
    end
    if (bus.s_resp) begin
      if (mdl_q.size() > 0) void'(mdl_q.pop_front());
      else mdl_err = 1;
    end
    if (push) mdl_q.push_back(pid);
  endtask

  // Model update for the coming edge, then land 2 time units after it to drive new inputs.
  task automatic advance();
    if (reset) mdl_reset(); else mdl_step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.m_req = '0; bus.m_cmd = '0; bus.m_addr = '0; bus.m_wdata = '0;
    bus.s_ack = 0; bus.s_resp = 0; bus.s_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs(); advance(); advance(); reset = 0;
  endtask

  task automatic wait_sreq(output bit found);
    found = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.s_req) begin found = 1; break; end
      advance();
    end
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    reset = 1; bus.m_req = 2'b11; bus.m_cmd = 2'b01; bus.s_ack = 1; bus.s_resp = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      obs = {bus.s_req, bus.m_ack, bus.m_resp, busy, resp_err};
      n_vec++;
      if (obs !== 7'b0) begin n_err++; $display("FAIL reset_outputs cyc%0d: got %b required 0000000", c, obs); end
      advance();
    end
    reset = 0; idle_inputs();
    advance();
  endtask

  task automatic test_single_read();
    bus.m_req = 2'b01; bus.m_cmd = 2'b00; bus.m_addr = {32'h0, 32'h10};
    #1; n_vec++;
    if (bus.s_req !== 1'b0) begin n_err++; $display("FAIL sr_idle: s_req got %b required 0", bus.s_req); end
    advance();
    #1; n_vec++;
    if (bus.s_req !== 1'b1 || bus.s_addr !== 32'h10 || bus.s_cmd !== 1'b0) begin
      n_err++; $display("FAIL sr_grant: s_req/addr/cmd got %b/%h/%b required 1/00000010/0", bus.s_req, bus.s_addr, bus.s_cmd);
    end
    n_vec++;
    if (bus.m_ack !== 2'b00) begin n_err++; $display("FAIL sr_noack: m_ack got %b required 00", bus.m_ack); end
    advance();
    bus.s_ack = 1; #1; n_vec++;
    if (bus.m_ack !== 2'b01) begin n_err++; $display("FAIL sr_ack: m_ack got %b required 01", bus.m_ack); end
    advance();
    bus.s_ack = 0; bus.m_req = 0; bus.s_resp = 1; bus.s_rdata = 32'h10; #1; n_vec++;
    if (bus.m_resp !== 2'b01 || bus.m_rdata !== {32'h0, 32'h10} || bus.m_ack !== 2'b00) begin
      n_err++; $display("FAIL sr_resp: m_resp/m_rdata/m_ack got %b/%h/%b required 01/%h/00", bus.m_resp, bus.m_rdata, bus.m_ack, {32'h0, 32'h10});
    end
    advance();
    bus.s_resp = 0; #1; n_vec++;
    if (busy !== 1'b0 || bus.m_resp !== 2'b00) begin n_err++; $display("FAIL sr_done: busy/m_resp got %b/%b required 0/00", busy, bus.m_resp); end
    advance();
  endtask

  task automatic test_round_robin();
    int grants; int cyc; logic [1:0] prev_ack; logic [1:0] exp; logic [31:0] exp_wd;
    do_reset();
    bus.m_cmd = 2'b11; bus.m_req = 2'b11;
    bus.m_addr = {32'h0000_2000, 32'h0000_1000}; bus.m_wdata = {32'hB1B1_0001, 32'hA0A0_0000};
    grants = 0; cyc = 0; prev_ack = '0;
    while (grants < 8 && cyc < 40) begin
      bus.s_ack = bus.s_req; #1;
      if (bus.m_ack !== 2'b00) begin
        exp = 2'b01 << (grants % 2);
        exp_wd = (grants % 2) ? 32'hB1B1_0001 : 32'hA0A0_0000;
        n_vec++;
        if (bus.m_ack !== exp || bus.s_wdata !== exp_wd) begin
          n_err++; $display("FAIL rr_order grant%0d: m_ack/s_wdata got %b/%h required %b/%h", grants, bus.m_ack, bus.s_wdata, exp, exp_wd);
        end
        n_vec++;
        if (prev_ack !== 2'b00) begin n_err++; $display("FAIL rr_pulse grant%0d: previous m_ack got %b required 00", grants, prev_ack); end
        grants++;
      end
      prev_ack = bus.m_ack;
      advance(); cyc++;
    end
    idle_inputs();
    n_vec++;
    if (grants != 8 || cyc != 16) begin n_err++; $display("FAIL rr_throughput: grants/cycles got %0d/%0d required 8/16", grants, cyc); end
    advance();
  endtask

  task automatic test_outstanding();
    int acks; logic [1:0] exp; bit found;
    int exp_ids[4] = '{1, 0, 1, 0};
    do_reset();
    bus.m_cmd = 2'b00; bus.m_req = 2'b11; bus.m_addr = {32'h0000_0B00, 32'h0000_0A00};
    acks = 0;
    for (int c = 0; c < 30 && acks < 4; c++) begin
      bus.s_ack = bus.s_req; #1;
      if (bus.m_ack !== 2'b00) begin
        exp = 2'b01 << (acks % 2); n_vec++;
        if (bus.m_ack !== exp) begin n_err++; $display("FAIL os_fill%0d: m_ack got %b required %b", acks, bus.m_ack, exp); end
        acks++;
      end
      advance();
      if (acks == 4) bus.m_req = 2'b01;
    end
    bus.s_ack = 0; n_vec++;
    if (acks != 4) begin n_err++; $display("FAIL os_fill_timeout: acks got %0d required 4", acks); end
    for (int c = 0; c < 6; c++) begin
      #1; n_vec++;
      if (bus.s_req !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL os_block cyc%0d: s_req/busy got %b/%b required 0/1", c, bus.s_req, busy); end
      advance();
    end
    bus.s_resp = 1; bus.s_rdata = 32'h0000_00D0; #1; n_vec++;
    if (bus.m_resp !== 2'b01 || bus.m_rdata !== {32'h0, 32'h0000_00D0}) begin
      n_err++; $display("FAIL os_first_resp: m_resp/m_rdata got %b/%h required 01/%h", bus.m_resp, bus.m_rdata, {32'h0, 32'h0000_00D0});
    end
    advance();
    bus.s_resp = 0;
    wait_sreq(found); #1; n_vec++;
    if (!found || bus.s_addr !== 32'h0000_0A00) begin n_err++; $display("FAIL os_fifth_grant: found/s_addr got %b/%h required 1/00000a00", found, bus.s_addr); end
    bus.s_ack = 1; #1; n_vec++;
    if (bus.m_ack !== 2'b01) begin n_err++; $display("FAIL os_fifth_ack: m_ack got %b required 01", bus.m_ack); end
    advance();
    bus.s_ack = 0; bus.m_req = 0;
    for (int j = 0; j < 4; j++) begin
      bus.s_resp = 1; bus.s_rdata = 32'hE0 + 32'(j); #1;
      exp = '0; exp[exp_ids[j]] = 1'b1; n_vec++;
      if (bus.m_resp !== exp || bus.m_rdata[32*exp_ids[j] +: 32] !== 32'hE0 + 32'(j) || bus.m_rdata[32*(1-exp_ids[j]) +: 32] !== 32'h0) begin
        n_err++; $display("FAIL os_drain%0d: m_resp/m_rdata got %b/%h required %b with word %0d=%h", j, bus.m_resp, bus.m_rdata, exp, exp_ids[j], 32'hE0 + 32'(j));
      end
      advance();
    end
    bus.s_resp = 0; #1; n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL os_idle: busy got %b required 0", busy); end
    advance();
  endtask

  task automatic test_simultaneous();
    int acks; bit found; logic [1:0] exp;
    int exp_ids[4] = '{1, 0, 1, 1};
    do_reset();
    bus.m_cmd = 2'b00; bus.m_req = 2'b11; bus.m_addr = {32'h0000_0B10, 32'h0000_0A10};
    acks = 0;
    for (int c = 0; c < 30 && acks < 3; c++) begin
      bus.s_ack = bus.s_req; #1;
      if (bus.m_ack !== 2'b00) acks++;
      advance();
    end
    bus.s_ack = 0; bus.m_req = 2'b10;
    wait_sreq(found);
    bus.s_ack = 1; bus.s_resp = 1; bus.s_rdata = 32'h0000_00C1; #1; n_vec++;
    if (!found || bus.m_ack !== 2'b10 || bus.m_resp !== 2'b01 || bus.m_rdata !== {32'h0, 32'h0000_00C1}) begin
      n_err++; $display("FAIL sim_push_pop: found/m_ack/m_resp/m_rdata got %b/%b/%b/%h required 1/10/01/%h", found, bus.m_ack, bus.m_resp, bus.m_rdata, {32'h0, 32'h0000_00C1});
    end
    advance();
    bus.s_ack = 0; bus.s_resp = 0;
    wait_sreq(found);
    bus.s_ack = 1; #1; n_vec++;
    if (!found || bus.m_ack !== 2'b10) begin n_err++; $display("FAIL sim_refill: found/m_ack got %b/%b required 1/10", found, bus.m_ack); end
    advance();
    bus.s_ack = 0; bus.m_req = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1; n_vec++;
      if (bus.s_req !== 1'b0) begin n_err++; $display("FAIL sim_full cyc%0d: s_req got %b required 0", c, bus.s_req); end
      advance();
    end
    bus.m_req = 2'b00;
    for (int j = 0; j < 4; j++) begin
      bus.s_resp = 1; bus.s_rdata = $urandom; #1;
      exp = '0; exp[exp_ids[j]] = 1'b1; n_vec++;
      if (bus.m_resp !== exp || bus.m_rdata[32*exp_ids[j] +: 32] !== bus.s_rdata) begin
        n_err++; $display("FAIL sim_drain%0d: m_resp/m_rdata got %b/%h required %b with word %0d=%h", j, bus.m_resp, bus.m_rdata, exp, exp_ids[j], bus.s_rdata);
      end
      advance();
    end
    bus.s_resp = 0; #1; n_vec++;
    if (busy !== 1'b0 || resp_err !== 1'b0) begin n_err++; $display("FAIL sim_idle: busy/resp_err got %b/%b required 0/0", busy, resp_err); end
    advance();
  endtask

  task automatic test_error_abort();
    bit found;
    do_reset();
    bus.s_resp = 1; bus.s_rdata = 32'hDEAD_BEEF; #1; n_vec++;
    if (bus.m_resp !== 2'b00 || bus.m_rdata !== '0) begin n_err++; $display("FAIL err_noresp: m_resp/m_rdata got %b/%h required 00/0", bus.m_resp, bus.m_rdata); end
    advance();
    bus.s_resp = 0; #1; n_vec++;
    if (resp_err !== 1'b1) begin n_err++; $display("FAIL err_set: resp_err got %b required 1", resp_err); end
    advance();
    bus.m_req = 2'b01; bus.m_cmd = 2'b01;
    wait_sreq(found);
    bus.s_ack = 1; advance();
    bus.s_ack = 0; bus.m_req = 2'b10; bus.m_cmd = 2'b00; bus.m_addr = {32'h0000_1234, 32'h0000_5678};
    wait_sreq(found); #1; n_vec++;
    if (!found || bus.s_addr !== 32'h0000_1234) begin n_err++; $display("FAIL ab_grant: found/s_addr got %b/%h required 1/00001234", found, bus.s_addr); end
    advance();
    bus.m_req = 2'b00; #1; n_vec++;
    if (bus.s_req !== 1'b1 || bus.m_ack !== 2'b00) begin n_err++; $display("FAIL ab_drop: s_req/m_ack got %b/%b required 1/00", bus.s_req, bus.m_ack); end
    advance();
    #1; n_vec++;
    if (bus.s_req !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL ab_idle: s_req/busy got %b/%b required 0/0", bus.s_req, busy); end
    advance();
    bus.m_req = 2'b11; bus.m_cmd = 2'b11;
    wait_sreq(found); #1;
    bus.s_ack = 1; #1; n_vec++;
    if (!found || bus.s_addr !== 32'h0000_1234 || bus.m_ack !== 2'b10) begin
      n_err++; $display("FAIL ab_regrant: found/s_addr/m_ack got %b/%h/%b required 1/00001234/10", found, bus.s_addr, bus.m_ack);
    end
    advance();
    idle_inputs(); #1; n_vec++;
    if (resp_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: resp_err got %b required 1", resp_err); end
    advance();
  endtask

  task automatic test_random();
    logic [N-1:0] exp_ack, exp_resp, acked;
    logic [N*32-1:0] exp_rdata;
    bit found;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.m_req[i] && $urandom_range(0, 2) == 0) begin
          bus.m_req[i] = 1'b1; bus.m_cmd[i] = 1'($urandom_range(0, 1));
          bus.m_addr[32*i +: 32] = $urandom; bus.m_wdata[32*i +: 32] = $urandom;
        end
      end
      bus.s_ack = bus.s_req && ($urandom_range(0, 2) != 0);
      bus.s_resp = (mdl_q.size() > 0) && ($urandom_range(0, 3) == 0);
      bus.s_rdata = $urandom;
      #1;
      exp_ack = '0; exp_resp = '0; exp_rdata = '0;
      if (mdl_active && bus.s_ack) exp_ack[mdl_gnt] = 1'b1;
      if (bus.s_resp && mdl_q.size() > 0) begin
        exp_resp[mdl_q[0]] = 1'b1; exp_rdata[32*mdl_q[0] +: 32] = bus.s_rdata;
      end
      n_vec++;
      if (bus.s_req !== mdl_active) begin n_err++; $display("FAIL rnd_sreq cyc%0d: got %b required %b", cyc, bus.s_req, mdl_active); end
      if (mdl_active) begin
        n_vec++;
        if (bus.s_addr !== bus.m_addr[32*mdl_gnt +: 32] || bus.s_cmd !== bus.m_cmd[mdl_gnt] || bus.s_wdata !== bus.m_wdata[32*mdl_gnt +: 32]) begin
          n_err++; $display("FAIL rnd_mux cyc%0d: addr/cmd/wdata got %h/%b/%h required master %0d %h/%b/%h", cyc, bus.s_addr, bus.s_cmd, bus.s_wdata,
                            mdl_gnt, bus.m_addr[32*mdl_gnt +: 32], bus.m_cmd[mdl_gnt], bus.m_wdata[32*mdl_gnt +: 32]);
        end
      end
      n_vec++;
      if (bus.m_ack !== exp_ack) begin n_err++; $display("FAIL rnd_ack cyc%0d: got %b required %b", cyc, bus.m_ack, exp_ack); end
      n_vec++;
      if (bus.m_resp !== exp_resp || bus.m_rdata !== exp_rdata) begin
        n_err++; $display("FAIL rnd_resp cyc%0d: m_resp/m_rdata got %b/%h required %b/%h", cyc, bus.m_resp, bus.m_rdata, exp_resp, exp_rdata);
      end
      n_vec++;
      if (busy !== (mdl_active || mdl_q.size() > 0) || resp_err !== mdl_err) begin
        n_err++; $display("FAIL rnd_status cyc%0d: busy/resp_err got %b/%b required %b/%b", cyc, busy, resp_err, mdl_active || mdl_q.size() > 0, mdl_err);
      end
      acked = bus.m_ack;
      advance();
      bus.m_req = bus.m_req & ~acked;
    end
    bus.s_ack = 0; bus.s_resp = 0; bus.m_req = 2'b11; bus.m_cmd = 2'b11;
    wait_sreq(found);
    reset = 1; #1; n_vec++;
    if (!found || bus.s_req !== 1'b0 || bus.m_ack !== 2'b00 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_async: found/s_req/m_ack/busy got %b/%b/%b/%b required 1/0/00/0", found, bus.s_req, bus.m_ack, busy);
    end
    idle_inputs(); advance(); reset = 0; advance();
  endtask

  initial begin
    reset = 1; idle_inputs(); mdl_reset();
    @(posedge clk); #2;
    test_reset();
    test_single_read();
    test_round_robin();
    test_outstanding();
    test_simultaneous();
    test_error_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
